// File: rtl/rb_seq_pkg.sv
// Shared constants for the register-bank sequencer: opcodes, instruction fields, FSM states.
// Z/C flag hardware is built only when RB_SEQ_FLAGS_EN is defined.
package rb_seq_pkg;

  localparam int unsigned W_DEFAULT = 16;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RX_MSB = 11;
  localparam int unsigned RX_LSB = 9;
  localparam int unsigned RY_MSB = 8;
  localparam int unsigned RY_LSB = 6;

  localparam logic [3:0] OP_MV  = 4'd0;
  localparam logic [3:0] OP_MVI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;

  typedef enum logic [2:0] {
    IDLE,
    RDX,
    RDY,
    IMM,
    WB,
    DONE
  } state_e;

  // Opcodes 8-15 are undefined and retire without a write.
  function automatic logic op_defined(input logic [3:0] op);
    return !op[3];
  endfunction

  // Opcodes that go through the ALU and therefore update the flags.
  function automatic logic op_sets_flags(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SRL);
  endfunction

endpackage

// File: rtl/rb_seq_alu.sv
// Combinational ALU for the sequencer: result and carry/borrow from (op, a, b).
// Flags derived from carry are only consumed when RB_SEQ_FLAGS_EN is defined.
module rb_seq_alu
  import rb_seq_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_MV:  result = b;
      OP_ADD: begin
        result = sum[W-1:0];
        carry  = sum[W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: result = a << b[3:0];
      OP_SRL: result = a >> b[3:0];
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rb_sequencer.sv
// Multi-cycle instruction sequencer driving an 8xW register bank (R7 = PC).
// Define RB_SEQ_FLAGS_EN to add registered Z/C flag outputs.
module rb_sequencer
  import rb_seq_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         Clock,
  input  logic         reset,
  input  logic         Run,
  input  logic [W-1:0] DIN,
  input  logic [W-1:0] q,
  output logic         Wr,
  output logic [2:0]   addr,
  output logic [W-1:0] data,
  output logic         incr_pc,
  output logic         Done,
  output logic         busy
`ifdef RB_SEQ_FLAGS_EN
  ,
  output logic         Z,
  output logic         C
`endif
);

  state_e state_q, state_d;
  logic [W-1:0] ir_q, ir_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] g_q, g_d;

  logic [3:0]   op;
  logic [2:0]   rx;
  logic [2:0]   ry;
  logic [W-1:0] alu_res;
  logic         alu_carry;

  assign op = ir_q[OP_MSB:OP_LSB];
  assign rx = ir_q[RX_MSB:RX_LSB];
  assign ry = ir_q[RY_MSB:RY_LSB];

  logic unused_ir;
  assign unused_ir = ^ir_q[RY_LSB-1:0];

  rb_seq_alu #(
    .W(W)
  ) u_alu (
    .op    (op),
    .a     (a_q),
    .b     (q),
    .result(alu_res),
    .carry (alu_carry)
  );

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    addr    = 3'd0;
    Wr      = 1'b0;
    incr_pc = 1'b0;
    Done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Run) begin
          ir_d    = DIN;
          state_d = RDX;
        end
      end
      RDX: begin
        addr    = rx;
        a_d     = q;
        incr_pc = 1'b1;
        if (op == OP_MVI) begin
          state_d = IMM;
        end else if (!op_defined(op)) begin
          state_d = DONE;
        end else begin
          state_d = RDY;
        end
      end
      RDY: begin
        addr    = ry;
        g_d     = alu_res;
        state_d = WB;
      end
      IMM: begin
        if (Run) begin
          g_d     = DIN;
          incr_pc = 1'b1;
          state_d = WB;
        end
      end
      WB: begin
        addr    = rx;
        Wr      = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data = g_q;
  assign busy = (state_q != IDLE);

`ifdef RB_SEQ_FLAGS_EN
  logic z_q, c_q;

  // Flags follow ALU ops only; mv, mvi and undefined opcodes leave them alone.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else if (state_q == RDY && op_sets_flags(op)) begin
      z_q <= (alu_res == '0);
      c_q <= alu_carry;
    end
  end

  assign Z = z_q;
  assign C = c_q;
`endif

endmodule
